// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (fetch / data) arbiter onto a single-cycle shared RAM.
// Optional starvation guard for fetch is enabled by defining MEM_ARB_STARVE_GUARD_EN.
`default_nettype none

module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [2:0]    dm_func3,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_wren,
    output logic [2:0]    mem_func3,
    input  logic [31:0]   mem_dout,
    output logic          if_stall,
    output logic          dm_stall
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    owner_e owner_q;
    owner_e owner_d;
    logic   force_fetch;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q;
    logic [3:0] starve_d;

    assign force_fetch = (starve_q == STARVE_LIM);

    // A denied fetch counts regardless of what the winning data access was.
    always_comb begin
        starve_d = 4'd0;
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    assign if_gnt   = !clear && if_req && (!dm_req || force_fetch);
    assign dm_gnt   = !clear && dm_req && !if_gnt;
    assign if_stall = if_req && !if_gnt;
    assign dm_stall = dm_req && !dm_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_din   = 32'd0;
        mem_wren  = 1'b0;
        mem_func3 = 3'd0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_din   = dm_wdata;
            mem_wren  = dm_we;
            mem_func3 = dm_func3;
        end
    end

    // Writes return nothing, so only reads claim the next cycle's read data.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            owner_d = OWN_DM;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign if_rvalid = !clear && (owner_q == OWN_IF);
    assign dm_rvalid = !clear && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_dout : 32'd0;
    assign dm_rdata  = dm_rvalid ? mem_dout : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a cycle model.
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW         = 8;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [2:0]    dm_func3;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [31:0]   dm_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic          mem_wren;
    logic [2:0]    mem_func3;
    logic [31:0]   mem_dout;
    logic          if_stall;
    logic          dm_stall;

    int checks   = 0;
    int failures = 0;

    // Reference state: who issued the read whose data arrives this cycle, and fetch denial streak.
    int exp_owner  = 0;   // 0 none, 1 fetch, 2 data
    int exp_streak = 0;

    mem_port_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clock     (clock),
        .clear     (clear),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_func3  (dm_func3),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wren  (mem_wren),
        .mem_func3 (mem_func3),
        .mem_dout  (mem_dout),
        .if_stall  (if_stall),
        .dm_stall  (dm_stall)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [31:0] wd, input logic [2:0] f3);
        logic          x_ig, x_dg, x_force;
        logic [AW-1:0] x_addr;
        logic [31:0]   x_din;
        logic [2:0]    x_f3;
        logic          x_wren;
        @(negedge clock);
        clear    = c;
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = wd;
        dm_func3 = f3;
        mem_dout = $urandom;
        #1;
        x_force = GUARD && (exp_streak == STARVE_MAX);
        x_ig    = !c && ir && (!dr || x_force);
        x_dg    = !c && dr && !x_ig;
        x_addr  = x_ig ? ia : (x_dg ? da : '0);
        x_din   = x_dg ? wd : 32'd0;
        x_f3    = x_dg ? f3 : 3'd0;
        x_wren  = x_dg && dw;

        check_val("grants", {62'd0, if_gnt, dm_gnt}, {62'd0, x_ig, x_dg});
        check_val("stalls", {62'd0, if_stall, dm_stall}, {62'd0, ir && !x_ig, dr && !x_dg});
        check_val("rvalid", {62'd0, if_rvalid, dm_rvalid},
                  {62'd0, !c && exp_owner == 1, !c && exp_owner == 2});
        check_val("if_rdata", {32'd0, if_rdata}, (!c && exp_owner == 1) ? {32'd0, mem_dout} : 64'd0);
        check_val("dm_rdata", {32'd0, dm_rdata}, (!c && exp_owner == 2) ? {32'd0, mem_dout} : 64'd0);
        check_val("mem_ctl", {52'd0, mem_wren, mem_func3, mem_addr}, {52'd0, x_wren, x_f3, x_addr});
        check_val("mem_din", {32'd0, mem_din}, {32'd0, x_din});

        if (c) begin
            exp_owner  = 0;
            exp_streak = 0;
        end else begin
            exp_owner  = x_ig ? 1 : ((x_dg && !dw) ? 2 : 0);
            exp_streak = (ir && !x_ig) ? ((exp_streak + 1 > STARVE_MAX) ? STARVE_MAX : exp_streak + 1) : 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 32'd0, 3'd0);
    endtask

    initial begin
        // Reset with requests active: nothing may be granted.
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h22, 32'h1, 3'd1);
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 32'h1, 3'd1);
        idle(2);

        // Fetch only.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, '0, 32'd0, 3'd0);
        idle(2);

        // Both requesting continuously, data read at 0x20.
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 32'd0, 3'd2);
        idle(2);

        // Data write.
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 3'b010);
        idle(2);

        // Fetch granted, then clear on the next edge.
        step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, '0, 32'd0, 3'd0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'd0, 3'd0);
        idle(3);

        // Alternating single requests.
        step(1'b0, 1'b1, 8'h30, 1'b0, 1'b0, '0, 32'd0, 3'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h31, 32'd0, 3'd4);
        step(1'b0, 1'b1, 8'h32, 1'b0, 1'b0, '0, 32'd0, 3'd0);
        idle(2);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0),
                 AW'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) == 0),
                 AW'($urandom),
                 $urandom,
                 3'($urandom));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
